bus_gate_arb: RTL and testbench
===============================

# bus_gate_arb

Parametrised, registered successor to the LC-3 datapath gate mux. Drives one shared bus from `NSRC` sources of `WIDTH` bits each. It has two modes: one-hot gate select, as used by the LC-3 control unit, and round-robin arbitration with a valid/ready handshake to the bus consumer. The block also detects illegal multi-hot gate selects and counts them. It sits between the datapath sources (PC, address adder, ALU, MDR, plus any future sources) and the bus consumers.

## Interface
Parameters:
- `WIDTH`, 16, bus and source word width.
- `NSRC`, 4, number of sources; must be at least 2 (elaboration-time assertion).

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `mode`  in  1  0 = gate mode, 1 = arbitrated mode.
- `gate`  in  NSRC  one-hot source select for gate mode; bit i selects source i.
- `req`  in  NSRC  per-source request for arbitrated mode.
- `src_data`  in  NSRC*WIDTH  packed source words; source i is at `[i*WIDTH +: WIDTH]`.
- `bus`  out  WIDTH  registered bus value.
- `grant`  out  NSRC  registered one-hot owner of `bus`; all zeros when `bus_valid` = 0.
- `bus_valid`  out  1  `bus` holds a word.
- `bus_ready`  in  1  consumer accepts the word.
- `conflict`  out  1  registered one-cycle pulse signalling a multi-hot `gate`.
- `conflict_cnt`  out  8  saturating count of conflict events.

## Operation
- Output register: holds `bus`, `grant` and `bus_valid`.
- Load condition: the register loads when `!bus_valid || bus_ready`. Otherwise it holds; `bus`, `grant` and `bus_valid` stay bit-stable, and `gate`, `req`, `src_data` and `mode` are ignored.
- Transfer: a transfer completes on a cycle with `bus_valid && bus_ready`.
- Gate mode, on load:
  - `gate` exactly one-hot (bit k): `bus` = source k, `grant` = `gate`, `bus_valid` = 1.
  - `gate` = 0: `bus` = 0, `grant` = 0, `bus_valid` = 0.
  - `gate` multi-hot: `bus` = 0, `grant` = 0, `bus_valid` = 0.
- Conflict detection:
  - Evaluated every cycle in gate mode, independent of the handshake.
  - A multi-hot `gate` sets `conflict` = 1 on the next cycle and increments `conflict_cnt`.
  - `conflict_cnt` saturates at 255.
  - In arbitrated mode, `conflict` = 0 and `conflict_cnt` holds.
- Arbitrated mode:
  - Round-robin pointer `ptr`, range 0..NSRC-1.
  - On load, the candidate set is `req`, minus the currently granted source if a transfer completes this cycle. A request is consumed by its transfer, and that source may re-request from the next cycle.
  - Grant the first candidate scanning from `ptr` upward, wrapping at NSRC-1 to 0.
  - Grant to source k: `bus` = source k, `grant` bit k set, `bus_valid` = 1, `ptr` ← (k+1) mod NSRC.
  - No candidates: `bus_valid` = 0, `bus` = 0, `grant` = 0, `ptr` unchanged.
- `ptr` holds in gate mode.
- A `mode` change takes effect at the next load; a held word is never disturbed.

## Timing
- Latency: 1 cycle from `gate`/`req`/`src_data` sampled on a load edge to `bus`.
- Throughput: 1 word per cycle across different sources. The same source back-to-back alone gets 1 word per 2 cycles because of the masking rule.
- Reset values: `bus` = 0, `grant` = 0, `bus_valid` = 0, `conflict` = 0, `conflict_cnt` = 0, `ptr` = 0.
- Reset mid-transfer: the word is dropped immediately (asynchronously); no partial state survives.
- `bus_ready` has no combinational path to any output; every output is a flop.
- Simultaneous conflict and saturation: `conflict` still pulses, and `conflict_cnt` stays at 255.

## Structure
- Package `bus_gate_pkg`:
  - `typedef enum logic {MODE_GATE=1'b0, MODE_ARB=1'b1} bus_mode_t;`
  - `localparam CNT_W = 8`.
- Sub-module `rr_pick` (parameter `N`): combinational rotated-priority picker.
  - Inputs: `cand[N]`, `ptr`.
  - Outputs: one-hot `pick`, index `pick_idx`, `any`.
- Top-level contents: the handshake/output register, gate-mode one-hot check, conflict counter and `ptr` register.

## Test plan
- Gate mode, `src_data` = {D3=A, D2=B, D1=C, D0=D}, `gate` = 4'b0100, `bus_ready` = 1 → next cycle `bus` = B, `grant` = 0100, `bus_valid` = 1; `gate` = 0 → `bus_valid` = 0, `bus` = 0.
- Gate mode, `gate` = 4'b1001 held 300 cycles → `bus_valid` = 0 and `conflict` = 1 each cycle from cycle 1; `conflict_cnt` reaches 255 and holds.
- Arbitrated mode, `req` = 4'b1111, `bus_ready` = 1, from reset → `grant` sequence 0001, 0010, 0100, 1000, 0001 (wrap).
- Backpressure: a word from source 2 is valid and `bus_ready` = 0 for 3 cycles while `req`/`src_data` toggle → `bus`/`grant` stable for all 3 cycles; `bus_ready` = 1 → next owner is source 3.
- Only `req[3]` held high, `bus_ready` = 1 → `bus_valid` pattern 1,0,1,0 with `grant` = 1000 on valid cycles.
- `Reset` asserted mid-cycle while `bus_valid` = 1 and `conflict_cnt` = 5 → all outputs 0 immediately, before the next edge; after release, `req` = 4'b1000 → grant 1000 (`ptr` restarted at 0).

Source files
------------

// File: rtl/bus_gate_pkg.sv
// Shared types and constants for the gated/arbitrated bus driver.
package bus_gate_pkg;

    typedef enum logic {MODE_GATE = 1'b0, MODE_ARB = 1'b1} bus_mode_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/bus_gate_arb_rr_pick.sv
// Rotated-priority picker: first set candidate scanning upward from ptr,
// wrapping at N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          any
);

    logic [IW-1:0] idx;

    function automatic int wrap(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'(wrap(int'(ptr) + i));
            if (!any && cand[idx]) begin
                any       = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/bus_gate_arb.sv
// Registered shared-bus driver: one-hot gate select or round-robin arbitration
// with a valid/ready handshake, plus multi-hot gate conflict counting.
module bus_gate_arb
    import bus_gate_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    mode,
    input  logic [NSRC-1:0]         gate,
    input  logic [NSRC-1:0]         req,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    output logic [WIDTH-1:0]        bus,
    output logic [NSRC-1:0]         grant,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic                    conflict,
    output logic [CNT_W-1:0]        conflict_cnt
);

    localparam int PW = $clog2(NSRC);

    if (NSRC < 2) begin : g_bad_nsrc
        $error("bus_gate_arb: NSRC must be at least 2");
    end

    bus_mode_t       cur_mode;
    logic            load;
    logic            xfer;
    logic            gate_onehot;
    logic            gate_multi;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] pick;
    logic [PW-1:0]   pick_idx;
    logic            any;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [NSRC-1:0] sel;
    logic [WIDTH-1:0] bus_nxt;

    assign cur_mode    = bus_mode_t'(mode);
    assign load        = !bus_valid || bus_ready;
    assign xfer        = bus_valid && bus_ready;
    assign gate_onehot = $onehot(gate);
    assign gate_multi  = !$onehot0(gate);

    // The word leaving this cycle has used its request; its owner re-competes next cycle.
    assign cand = req & ~(xfer ? grant : '0);

    rr_pick #(.N(NSRC), .IW(PW)) u_pick (
        .cand     (cand),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    assign ptr_nxt = (pick_idx == PW'(NSRC - 1)) ? '0 : pick_idx + 1'b1;
    assign sel     = (cur_mode == MODE_ARB) ? pick : (gate_onehot ? gate : '0);

    always_comb begin
        bus_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel[i]) bus_nxt = bus_nxt | src_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (Reset) begin
            bus       <= '0;
            grant     <= '0;
            bus_valid <= 1'b0;
            ptr       <= '0;
        end else if (load) begin
            bus       <= bus_nxt;
            grant     <= sel;
            bus_valid <= |sel;
            if (cur_mode == MODE_ARB && any) ptr <= ptr_nxt;
        end
    end

    // Conflict tracking ignores the handshake; it watches gate every cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else if (cur_mode == MODE_GATE && gate_multi) begin
            conflict <= 1'b1;
            if (conflict_cnt != {CNT_W{1'b1}}) conflict_cnt <= conflict_cnt + 1'b1;
        end else begin
            conflict <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_gate_arb.sv
// Scoreboarded bench for bus_gate_arb: a behavioural model predicts each
// registered output, queued when stimulus is applied and compared after the edge.
module tb_bus_gate_arb;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        mode;
    logic [3:0]  gate;
    logic [3:0]  req;
    logic [63:0] src_data;
    logic        bus_ready;
    logic [15:0] bus;
    logic [3:0]  grant;
    logic        bus_valid;
    logic        conflict;
    logic [7:0]  conflict_cnt;

    bus_gate_arb #(.WIDTH(16), .NSRC(4)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .mode         (mode),
        .gate         (gate),
        .req          (req),
        .src_data     (src_data),
        .bus          (bus),
        .grant        (grant),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] bus;
        logic [3:0]  grant;
        logic        valid;
        logic        conflict;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   m_ptr;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    localparam logic [15:0] WA = 16'hAAAA, WB = 16'hBBBB, WC = 16'hCCCC, WD = 16'hDDDD;

    function automatic logic [15:0] word(input int k);
        return src_data[k*16 +: 16];
    endfunction

    task automatic model_reset();
        m     = '0;
        m_ptr = 0;
        sb.delete();
    endtask

    // Reference behaviour for one clock edge, from the current inputs and model state.
    task automatic predict();
        exp_t       n;
        logic       ld, xf, found;
        logic [3:0] cand;
        n  = m;
        ld = !m.valid || bus_ready;
        xf = m.valid && bus_ready;
        if (mode == 1'b0 && $countones(gate) > 1) begin
            n.conflict = 1'b1;
            if (m.cnt != 8'hFF) n.cnt = m.cnt + 8'd1;
        end else begin
            n.conflict = 1'b0;
        end
        if (ld) begin
            n.bus = '0; n.grant = '0; n.valid = 1'b0;
            if (mode == 1'b0) begin
                if ($countones(gate) == 1)
                    for (int k = 0; k < 4; k++)
                        if (gate[k]) begin n.bus = word(k); n.grant = gate; n.valid = 1'b1; end
            end else begin
                cand  = req & ~(xf ? m.grant : 4'b0000);
                found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    int k;
                    k = (m_ptr + i) % 4;
                    if (!found && cand[k]) begin
                        found   = 1'b1;
                        n.bus   = word(k);
                        n.grant = 4'b0001 << k;
                        n.valid = 1'b1;
                        m_ptr   = (k + 1) % 4;
                    end
                end
            end
        end
        sb.push_back(n);
        m = n;
    endtask

    // Advance one edge and compare the DUT against the oldest queued prediction.
    task automatic step(input string name);
        exp_t e, got;
        predict();
        @(posedge Clk);
        #1;
        e   = sb.pop_front();
        got = '{bus: bus, grant: grant, valid: bus_valid, conflict: conflict, cnt: conflict_cnt};
        total_cnt++;
        if (got !== e)
            $display("FAIL %s: got bus=%h grant=%b valid=%b conflict=%b cnt=%0d, expected bus=%h grant=%b valid=%b conflict=%b cnt=%0d",
                     name, got.bus, got.grant, got.valid, got.conflict, got.cnt,
                     e.bus, e.grant, e.valid, e.conflict, e.cnt);
        else
            pass_cnt++;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        mode = 1'b0; gate = '0; req = '0; bus_ready = 1'b1;
        src_data = {WA, WB, WC, WD};
        Reset = 1'b1;
        model_reset();
        #2;
        total_cnt++;
        if ({bus, grant, bus_valid, conflict, conflict_cnt} !== '0)
            $display("FAIL reset_state: got bus=%h grant=%b valid=%b conflict=%b cnt=%0d, expected all zero",
                     bus, grant, bus_valid, conflict, conflict_cnt);
        else pass_cnt++;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_gate();
        mode = 1'b0; bus_ready = 1'b1; src_data = {WA, WB, WC, WD};
        gate = 4'b0100;
        step("gate_sel2");
        total_cnt++;
        if (bus !== WB || grant !== 4'b0100 || bus_valid !== 1'b1)
            $display("FAIL gate_sel2_const: got bus=%h grant=%b valid=%b, expected bus=%h grant=0100 valid=1", bus, grant, bus_valid, WB);
        else pass_cnt++;
        gate = 4'b0000;
        step("gate_none");
        total_cnt++;
        if (bus !== 16'h0 || bus_valid !== 1'b0)
            $display("FAIL gate_none_const: got bus=%h valid=%b, expected bus=0000 valid=0", bus, bus_valid);
        else pass_cnt++;
        gate = 4'b0001; step("gate_sel0");
        gate = 4'b1000; step("gate_sel3");
    endtask

    task automatic test_conflict();
        mode = 1'b0; bus_ready = 1'b1; gate = 4'b1001;
        for (int c = 0; c < 300; c++) begin
            step("conflict_hold");
            total_cnt++;
            if (conflict !== 1'b1 || bus_valid !== 1'b0)
                $display("FAIL conflict_pulse cycle %0d: got conflict=%b valid=%b, expected conflict=1 valid=0", c, conflict, bus_valid);
            else pass_cnt++;
        end
        total_cnt++;
        if (conflict_cnt !== 8'd255)
            $display("FAIL conflict_saturate: got cnt=%0d, expected 255", conflict_cnt);
        else pass_cnt++;
        mode = 1'b1; req = 4'b0000;
        step("conflict_arb_hold");
    endtask

    task automatic test_round_robin();
        logic [3:0] want [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        mode = 1'b1; req = 4'b1111; bus_ready = 1'b1; src_data = {WA, WB, WC, WD};
        for (int i = 0; i < 5; i++) begin
            step("rr_seq");
            total_cnt++;
            if (grant !== want[i] || bus_valid !== 1'b1)
                $display("FAIL rr_order step %0d: got grant=%b valid=%b, expected grant=%b valid=1", i, grant, bus_valid, want[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        do_reset();
        mode = 1'b1; bus_ready = 1'b1; req = 4'b0100; src_data = {WA, WB, WC, WD};
        step("bp_grant2");
        held = bus;
        bus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req      = (i % 2 == 0) ? 4'b1011 : 4'b0111;
            src_data = {$urandom, $urandom};
            step("bp_hold");
            total_cnt++;
            if (bus !== held || grant !== 4'b0100 || bus_valid !== 1'b1)
                $display("FAIL bp_stable cycle %0d: got bus=%h grant=%b valid=%b, expected bus=%h grant=0100 valid=1",
                         i, bus, grant, bus_valid, held);
            else pass_cnt++;
        end
        bus_ready = 1'b1; req = 4'b1111;
        step("bp_release");
        total_cnt++;
        if (grant !== 4'b1000)
            $display("FAIL bp_next_owner: got grant=%b, expected 1000", grant);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic want_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        mode = 1'b1; bus_ready = 1'b1; req = 4'b1000; src_data = {WA, WB, WC, WD};
        for (int i = 0; i < 4; i++) begin
            step("b2b_same_src");
            total_cnt++;
            if (bus_valid !== want_v[i] || grant !== (want_v[i] ? 4'b1000 : 4'b0000))
                $display("FAIL b2b_pattern step %0d: got valid=%b grant=%b, expected valid=%b", i, bus_valid, grant, want_v[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 1'b0; bus_ready = 1'b1; src_data = {WA, WB, WC, WD};
        gate = 4'b0011;
        for (int i = 0; i < 5; i++) step("rm_conflict");
        gate = 4'b0010; bus_ready = 1'b0;
        step("rm_load");
        total_cnt++;
        if (bus_valid !== 1'b1 || conflict_cnt !== 8'd5)
            $display("FAIL rm_setup: got valid=%b cnt=%0d, expected valid=1 cnt=5", bus_valid, conflict_cnt);
        else pass_cnt++;
        #2 Reset = 1'b1;
        model_reset();
        #1;
        total_cnt++;
        if ({bus, grant, bus_valid, conflict, conflict_cnt} !== '0)
            $display("FAIL rm_async_clear: got bus=%h grant=%b valid=%b conflict=%b cnt=%0d, expected all zero",
                     bus, grant, bus_valid, conflict, conflict_cnt);
        else pass_cnt++;
        #2 Reset = 1'b0;
        mode = 1'b1; bus_ready = 1'b1; req = 4'b1000;
        step("rm_after_req3");
        total_cnt++;
        if (grant !== 4'b1000)
            $display("FAIL rm_grant: got grant=%b, expected 1000", grant);
        else pass_cnt++;
        req = 4'b1111;
        step("rm_after_wrap");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_gate();
        test_conflict();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
